// File: rtl/round_countdown_if.sv
// round_countdown_if: groups the game-controller side signals of the round timer.
//   tick_in   : one-cycle 1 Hz strobe, synchronous to clk_in
//   start     : one-cycle request to load the round length and run
//   pause     : level, high holds the count
//   secs_tens : BCD tens digit of remaining seconds
//   secs_ones : BCD ones digit of remaining seconds
//   running   : high while counting
//   warn      : low-time indicator
//   time_up   : level, high once the round has expired
//   expired   : one-cycle pulse on expiry
// master = game controller / tick source, slave = round_countdown.
interface round_countdown_if;
    logic       tick_in;
    logic       start;
    logic       pause;
    logic [3:0] secs_tens;
    logic [3:0] secs_ones;
    logic       running;
    logic       warn;
    logic       time_up;
    logic       expired;

    modport master (
        output tick_in, start, pause,
        input  secs_tens, secs_ones, running, warn, time_up, expired
    );

    modport slave (
        input  tick_in, start, pause,
        output secs_tens, secs_ones, running, warn, time_up, expired
    );
endinterface

// File: rtl/round_countdown.sv
// round_countdown: whack-a-mole round timer. Counts down in two BCD digits
// from START_SECS on each tick_in strobe, with start/restart and pause
// handling, a low-time warning and an expiry report.
//   clk_in : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : round_countdown_if.slave (tick/start/pause in, digits and status out)
// All outputs are registered.
module round_countdown #(
    parameter int START_SECS = 60,
    parameter int WARN_SECS  = 10
) (
    input  logic               clk_in,
    input  logic               rst_n,
    round_countdown_if.slave   bus
);

    if (START_SECS < 0 || START_SECS > 99) begin : g_bad_start
        $error("round_countdown: START_SECS must be in 0..99");
    end
    if (WARN_SECS < 0 || WARN_SECS > 99) begin : g_bad_warn
        $error("round_countdown: WARN_SECS must be in 0..99");
    end

    localparam logic [3:0] START_T = 4'(START_SECS / 10);
    localparam logic [3:0] START_O = 4'(START_SECS % 10);
    localparam logic [3:0] WARN_T  = 4'(WARN_SECS / 10);
    localparam logic [3:0] WARN_O  = 4'(WARN_SECS % 10);
    localparam logic       START_ZERO = (START_SECS == 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state, state_nx;
    logic [3:0] tens, ones;
    logic [3:0] tens_nx, ones_nx;
    logic       expired_nx;
    logic       running_nx;
    logic       warn_nx;
    logic       nonzero_nx;
    logic       le_warn_nx;

    // Next-state and next-count; start has priority over pause, pause over tick.
    always_comb begin
        state_nx   = state;
        tens_nx    = tens;
        ones_nx    = ones;
        expired_nx = 1'b0;
        if (bus.start) begin
            tens_nx = START_T;
            ones_nx = START_O;
            if (START_ZERO) begin
                state_nx   = DONE;
                expired_nx = 1'b1;
            end else if (bus.pause) begin
                state_nx = PAUSED;
            end else begin
                state_nx = RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    // A tick coincident with pause is still consumed.
                    if (bus.tick_in && (tens != 4'd0 || ones != 4'd0)) begin
                        if (ones != 4'd0) begin
                            ones_nx = ones - 4'd1;
                        end else begin
                            ones_nx = 4'd9;
                            tens_nx = tens - 4'd1;
                        end
                    end
                    if (bus.tick_in && tens == 4'd0 && ones == 4'd1) begin
                        state_nx   = DONE;
                        expired_nx = 1'b1;
                    end else if (bus.pause) begin
                        state_nx = PAUSED;
                    end
                end
                PAUSED: begin
                    if (!bus.pause) begin
                        state_nx = RUN;
                    end
                end
                default: begin
                    state_nx = state;
                end
            endcase
        end
    end

    // Warning is derived from the next count so it updates with the digits.
    always_comb begin
        running_nx = (state_nx == RUN);
        nonzero_nx = (tens_nx != 4'd0) || (ones_nx != 4'd0);
        le_warn_nx = (tens_nx < WARN_T) || ((tens_nx == WARN_T) && (ones_nx <= WARN_O));
        warn_nx    = running_nx && nonzero_nx && le_warn_nx;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tens          <= START_T;
            ones          <= START_O;
            bus.running   <= 1'b0;
            bus.warn      <= 1'b0;
            bus.time_up   <= 1'b0;
            bus.expired   <= 1'b0;
        end else begin
            state         <= state_nx;
            tens          <= tens_nx;
            ones          <= ones_nx;
            bus.running   <= running_nx;
            bus.warn      <= warn_nx;
            bus.time_up   <= (state_nx == DONE);
            bus.expired   <= expired_nx;
        end
    end

    assign bus.secs_tens = tens;
    assign bus.secs_ones = ones;

endmodule

// File: tb/tb_round_countdown.sv
// tb_round_countdown: directed bench for round_countdown with START_SECS=12,
// WARN_SECS=10, plus a second instance with START_SECS=0.
module tb_round_countdown;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk_in = ~clk_in;

    round_countdown_if bus_a ();
    round_countdown_if bus_b ();

    round_countdown #(.START_SECS(12), .WARN_SECS(10)) dut_a (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus_a.slave)
    );

    round_countdown #(.START_SECS(0), .WARN_SECS(10)) dut_b (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus_b.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks digits, running, warn, time_up, expired of instance A.
    task automatic chk_a(input string tag, input logic [7:0] digits,
                         input logic run, input logic wrn, input logic tup, input logic exp_p);
        chk({tag, ".digits"},  {24'd0, bus_a.secs_tens, bus_a.secs_ones}, {24'd0, digits});
        chk({tag, ".running"}, {31'd0, bus_a.running}, {31'd0, run});
        chk({tag, ".warn"},    {31'd0, bus_a.warn},    {31'd0, wrn});
        chk({tag, ".time_up"}, {31'd0, bus_a.time_up}, {31'd0, tup});
        chk({tag, ".expired"}, {31'd0, bus_a.expired}, {31'd0, exp_p});
    endtask

    // Called at posedge+1: drive inputs, wait one edge, return at posedge+1.
    task automatic step(input logic t, input logic s, input logic p);
        bus_a.tick_in = t;
        bus_a.start   = s;
        bus_a.pause   = p;
        @(posedge clk_in);
        #1;
        bus_a.tick_in = 1'b0;
        bus_a.start   = 1'b0;
    endtask

    initial begin
        bus_a.tick_in = 1'b0;
        bus_a.start   = 1'b0;
        bus_a.pause   = 1'b0;
        bus_b.tick_in = 1'b0;
        bus_b.start   = 1'b0;
        bus_b.pause   = 1'b0;

        repeat (3) @(posedge clk_in);
        #1;
        chk_a("reset", 8'h12, 0, 0, 0, 0);
        chk("reset_b.digits", {24'd0, bus_b.secs_tens, bus_b.secs_ones}, 32'h00);
        chk("reset_b.time_up", {31'd0, bus_b.time_up}, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk_in);
        #1;

        // Ticks without start are ignored in IDLE.
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        chk_a("idle_ticks", 8'h12, 0, 0, 0, 0);

        // Start and count down into the warning zone.
        step(0, 1, 0);
        chk_a("start", 8'h12, 1, 0, 0, 0);
        step(1, 0, 0);
        chk_a("tick11", 8'h11, 1, 0, 0, 0);
        step(1, 0, 0);
        chk_a("tick10", 8'h10, 1, 1, 0, 0);

        // Pause from 10: ticks ignored, running and warn drop.
        step(0, 0, 1);
        chk_a("pause", 8'h10, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1);
        chk_a("paused_ticks", 8'h10, 0, 0, 0, 0);
        step(0, 0, 0);
        chk_a("resume", 8'h10, 1, 1, 0, 0);
        step(1, 0, 0);
        chk_a("tick09", 8'h09, 1, 1, 0, 0);

        // Tick coincident with pause still decrements, then pauses.
        step(1, 0, 1);
        chk_a("tick_pause", 8'h08, 0, 0, 0, 0);
        step(0, 0, 0);
        chk_a("resume2", 8'h08, 1, 1, 0, 0);

        // Back-to-back ticks each decrement.
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk_a("b2b", 8'h05, 1, 1, 0, 0);

        // Restart with a coincident tick: reload, tick discarded.
        step(1, 1, 0);
        chk_a("restart_tick", 8'h12, 1, 0, 0, 0);

        // Run to the end.
        for (int i = 0; i < 11; i++) step(1, 0, 0);
        chk_a("at01", 8'h01, 1, 1, 0, 0);
        step(1, 0, 0);
        chk_a("expire", 8'h00, 0, 0, 1, 1);
        step(0, 0, 0);
        chk_a("done_hold", 8'h00, 0, 0, 1, 0);
        step(1, 0, 0);
        step(1, 0, 1);
        chk_a("done_ticks", 8'h00, 0, 0, 1, 0);

        // Start from DONE clears time_up and counts again.
        step(0, 1, 0);
        chk_a("restart_done", 8'h12, 1, 0, 0, 0);
        step(1, 0, 0);
        chk_a("restart_tick11", 8'h11, 1, 0, 0, 0);

        // Start with pause high lands in PAUSED.
        step(0, 1, 1);
        chk_a("start_paused", 8'h12, 0, 0, 0, 0);
        step(1, 0, 0);
        chk_a("start_paused_rel", 8'h12, 1, 0, 0, 0);
        step(1, 0, 0);
        chk_a("pre_reset", 8'h11, 1, 0, 0, 0);

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        chk_a("async_reset", 8'h12, 0, 0, 0, 0);
        @(posedge clk_in);
        #3 rst_n = 1'b1;
        @(posedge clk_in);
        #1;
        step(1, 0, 0);
        chk_a("post_reset_idle", 8'h12, 0, 0, 0, 0);

        // START_SECS=0 instance: start goes straight to DONE with one expired pulse.
        bus_b.start = 1'b1;
        @(posedge clk_in);
        #1;
        bus_b.start = 1'b0;
        chk("b_start.digits",  {24'd0, bus_b.secs_tens, bus_b.secs_ones}, 32'h00);
        chk("b_start.time_up", {31'd0, bus_b.time_up}, 32'd1);
        chk("b_start.expired", {31'd0, bus_b.expired}, 32'd1);
        chk("b_start.running", {31'd0, bus_b.running}, 32'd0);
        @(posedge clk_in);
        #1;
        chk("b_after.expired", {31'd0, bus_b.expired}, 32'd0);
        chk("b_after.time_up", {31'd0, bus_b.time_up}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/round_countdown.md
Name: round_countdown

Overview:
- Consumer end of the one-second tick: takes the single-cycle `tick_in` strobe from the 1 Hz tick generator and runs the whack-a-mole round timer.
- Counts down from a loadable start value in two BCD digits for the seven-segment display path.
- Handles start, restart and pause requests from the game controller.
- Reports low-time warning and round expiry to the game FSM.

Parameters:
- START_SECS, 60, round length in seconds; legal range 0..99; out-of-range is an elaboration error.
- WARN_SECS, 10, `warn` asserts while the remaining count is ≤ this value and > 0; legal range 0..99.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- tick_in  input  1  one-cycle pulse, once per second, synchronous to clk_in.
- start  input  1  one-cycle request: load START_SECS and run; accepted in any state.
- pause  input  1  level; high holds the count.
- secs_tens  output  4  BCD tens digit of remaining seconds.
- secs_ones  output  4  BCD ones digit of remaining seconds.
- running  output  1  high in RUN state.
- warn  output  1  low-time indicator.
- time_up  output  1  level; high in DONE state.
- expired  output  1  one-cycle pulse on entry to DONE.

Behaviour:
- Clock and reset: one clock, clk_in; reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE; digits equal START_SECS in BCD; running=0, warn=0, time_up=0, expired=0.
- All outputs are registered. Every effect below appears on the clock edge after the triggering input is sampled.
- States: IDLE, RUN, PAUSED, DONE.
- Priority each cycle: start > pause > tick_in.
- start in any state:
  - Digits reload START_SECS.
  - State goes to RUN, or to PAUSED if pause is high in the same cycle.
  - tick_in in the same cycle is discarded.
  - If START_SECS=0: go straight to DONE, with expired pulsed once.
- RUN:
  - pause=1: go to PAUSED. A coincident tick is still consumed (one decrement) before pausing.
  - tick_in=1 otherwise: decrement the count.
- PAUSED:
  - pause=0: return to RUN.
  - tick_in is ignored; the count holds.
- IDLE and DONE: tick_in and pause are ignored; the count holds.
- Decrement:
  - BCD. If ones>0, ones−1.
  - Otherwise ones=9 and tens−1.
  - No binary intermediate.
- Expiry:
  - When a tick decrements 01 to 00: state goes to DONE, time_up=1, and expired=1 for exactly that one cycle.
  - The count never wraps below 00.
- warn = running·(count ≤ WARN_SECS)·(count ≠ 0). It is registered alongside the count, so it is never visibly one tick stale.
- running is deasserted in the same cycle PAUSED or DONE is entered.
- time_up clears only on start or reset.
- Async reset mid-round: all state returns to reset values immediately, independent of the clock; no expired pulse.
- Back-to-back ticks on consecutive cycles are legal: each one decrements.

Test Plan (START_SECS=12, WARN_SECS=10 for sim):
- Reset release, no start, 5 ticks → digits stay 1/2; running=0; time_up=0.
- Pulse start, then 3 ticks → running=1; digits 0/9 after the third tick; warn rises on the cycle the count becomes 10.
- From 10: pause=1 for 4 ticks, then pause=0 and 1 tick → digits hold at 1/0 while paused, then 0/9; running drops and returns accordingly.
- Run to end → on the tick 01→00, expired high exactly one cycle; time_up=1; warn=0; running=0; further ticks leave 0/0.
- start asserted with a coincident tick while at 05 in RUN → digits 1/2 next cycle, no decrement; from DONE, start clears time_up and resumes counting.
- Assert rst_n=0 mid-round between clock edges → outputs reset asynchronously to 1/2 and IDLE; with START_SECS=0 in a second configuration, start → DONE with a single expired pulse.
